// File: rtl/mem_access_ctrl.sv
// Host-side access controller for the bitcell array: one request at a time,
// sequenced as SETUP -> STROBE -> HOLD so data and rw frame every row select.
module mem_access_ctrl #(
  parameter int WORDS         = 8,
  parameter int DATA_W        = 8,
  parameter int ADDR_W        = 3,
  parameter int STROBE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [WORDS-1:0]  mem_sel,
  output logic              mem_rw,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_e;

  localparam int                CNT_W       = 4;
  localparam logic [CNT_W-1:0]  STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [ADDR_W:0]   WORDS_L     = (ADDR_W + 1)'(WORDS);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WORDS-1:0]    sel_q, sel_d;
  logic                rw_q, rw_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic                err_q, err_d;

  logic                in_range;
  logic [WORDS-1:0]    addr_onehot;

  assign in_range = ({1'b0, addr_q} < WORDS_L);

  always_comb begin
    addr_onehot = '0;
    for (int i = 0; i < WORDS; i++) begin
      if ({1'b0, addr_q} == (ADDR_W + 1)'(i)) addr_onehot[i] = 1'b1;
    end
  end

  // req_ready is the only combinational output; it must read low throughout reset.
  assign req_ready = (state_q == S_IDLE) && rst_n;

  always_comb begin
    // NOTE: every next-state signal defaults to its current value first, so no path leaves one unassigned and no latch is inferred.
    state_d     = state_q;
    we_d        = we_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    rw_d        = rw_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    err_d       = err_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          state_d = S_SETUP;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rw_d    = req_we;
        end
      end
      S_SETUP: begin
        err_d = !in_range;
        if (in_range) begin
          state_d = S_STROBE;
          sel_d   = addr_onehot;
          cnt_d   = STROBE_LAST;
        end else begin
          state_d     = S_RESP;
          rw_d        = 1'b0;
          rdata_d     = '0;
          rsp_valid_d = 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          // Capture on the edge that ends the last strobe cycle, while the row still drives the bus.
          state_d = S_HOLD;
          sel_d   = '0;
          rdata_d = we_q ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        state_d     = S_RESP;
        rw_d        = 1'b0;
        rsp_valid_d = 1'b1;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      rw_q        <= 1'b0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      rw_q        <= rw_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign mem_sel   = sel_q;
  assign mem_rw    = rw_q;
  assign mem_wdata = wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: default instance against a transaction-level model
// and bitcell array, plus a WORDS=6 / STROBE_CYCLES=3 instance with directed checks.
module tb_mem_access_ctrl;

  localparam int A_S     = 1;
  localparam int A_WORDS = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Default instance
  logic       a_req_valid, a_req_ready, a_req_we;
  logic [2:0] a_req_addr;
  logic [7:0] a_req_wdata;
  logic       a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [7:0] a_rsp_rdata;
  logic [7:0] a_mem_sel;
  logic       a_mem_rw;
  logic [7:0] a_mem_wdata, a_mem_rdata;

  mem_access_ctrl u_a (
    .clk(clk), .rst_n(rst_n),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_we(a_req_we),
    .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .mem_sel(a_mem_sel), .mem_rw(a_mem_rw),
    .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
  );

  // Six-row, three-cycle-strobe instance
  logic       b_req_valid, b_req_ready, b_req_we;
  logic [2:0] b_req_addr;
  logic [7:0] b_req_wdata;
  logic       b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [7:0] b_rsp_rdata;
  logic [5:0] b_mem_sel;
  logic       b_mem_rw;
  logic [7:0] b_mem_wdata, b_mem_rdata;

  mem_access_ctrl #(.WORDS(6), .DATA_W(8), .ADDR_W(3), .STROBE_CYCLES(3)) u_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_we(b_req_we),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .mem_sel(b_mem_sel), .mem_rw(b_mem_rw),
    .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Bitcell array seen by the default instance: selected row drives the bus on reads,
  // latches wdata at the clock edge on writes.
  logic [7:0] arr [8] = '{default: 8'h00};

  always_comb begin
    a_mem_rdata = 8'h00;
    for (int i = 0; i < 8; i++)
      if (a_mem_sel[i] && !a_mem_rw) a_mem_rdata = arr[i];
  end

  always @(posedge clk) begin
    if (a_mem_rw)
      for (int i = 0; i < 8; i++)
        if (a_mem_sel[i]) arr[i] <= a_mem_wdata;
  end

  // Transaction-level reference: cycles elapsed since the handshake decide the phase.
  logic [7:0] ref_mem   [8] = '{default: 8'h00};
  bit         ref_known [8] = '{default: 1'b1};
  bit         m_busy = 1'b0;
  int         m_k, m_addr;
  logic       m_we, m_err, m_rd_known;
  logic [7:0] m_rd, m_last_wd = 8'h00;
  bit         m_resp, m_strobe, m_drive;
  logic [7:0] exp_sel;
  logic       exp_rw;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_req_ready", a_req_ready, 0);
        check("rst_rsp_valid", a_rsp_valid, 0);
        check("rst_rsp_err",   a_rsp_err, 0);
        check("rst_rsp_rdata", a_rsp_rdata, 0);
        check("rst_mem_sel",   a_mem_sel, 0);
        check("rst_mem_rw",    a_mem_rw, 0);
        check("rst_mem_wdata", a_mem_wdata, 0);
        if (m_busy && m_we) ref_known[m_addr] = 1'b0;
        m_busy    = 1'b0;
        m_last_wd = 8'h00;
      end else begin
        m_resp   = m_busy && (m_err ? (m_k >= 2) : (m_k >= 3 + A_S));
        m_strobe = m_busy && !m_err && (m_k >= 2) && (m_k <= 1 + A_S);
        m_drive  = m_busy && !m_resp;
        exp_sel  = m_strobe ? (8'b1 << m_addr) : 8'b0;
        exp_rw   = m_drive ? m_we : 1'b0;
        check("req_ready", a_req_ready, !m_busy);
        check("rsp_valid", a_rsp_valid, m_resp);
        check("mem_sel",   a_mem_sel, exp_sel);
        check("mem_rw",    a_mem_rw, exp_rw);
        check("mem_wdata", a_mem_wdata, m_last_wd);
        if (m_resp) begin
          check("rsp_err", a_rsp_err, m_err);
          if (m_rd_known) check("rsp_rdata", a_rsp_rdata, m_rd);
        end
        if (!m_busy) begin
          if (a_req_valid) begin
            m_busy     = 1'b1;
            m_k        = 1;
            m_we       = a_req_we;
            m_addr     = int'(a_req_addr);
            m_last_wd  = a_req_wdata;
            m_err      = (m_addr >= A_WORDS);
            m_rd       = 8'h00;
            m_rd_known = 1'b1;
            if (!m_err) begin
              if (m_we) begin
                ref_mem[m_addr]   = a_req_wdata;
                ref_known[m_addr] = 1'b1;
              end else begin
                m_rd       = ref_mem[m_addr];
                m_rd_known = ref_known[m_addr];
              end
            end
          end
        end else if (m_resp && a_rsp_ready) begin
          m_busy = 1'b0;
        end else begin
          m_k++;
        end
      end
    end
  end

  // Per-cycle log of the array lines, indexed by cycles since the handshake.
  logic [7:0] sel_log [32];
  logic       rw_log  [32];
  logic [7:0] wd_log  [32];

  task automatic a_req(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                       input int hold, output logic [7:0] rd, output logic err, output int lat);
    int g;
    @(posedge clk); #2;
    a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wd;
    a_rsp_ready = (hold == 0);
    g = 0;
    do begin @(negedge clk); g++; end while (!a_req_ready && g < 50);
    check("a_handshake_wait", (g < 50), 1);
    @(posedge clk); #2;
    a_req_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      sel_log[lat] = a_mem_sel; rw_log[lat] = a_mem_rw; wd_log[lat] = a_mem_wdata;
    end while (!a_rsp_valid && lat < 30);
    rd  = a_rsp_rdata;
    err = a_rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_rsp_valid", a_rsp_valid, 1);
      check("hold_req_ready", a_req_ready, 0);
      check("hold_mem_sel",   a_mem_sel, 0);
    end
    if (hold > 0) begin
      @(posedge clk); #2;
      a_rsp_ready = 1'b1;
    end
    @(posedge clk); #2;
    check("rsp_taken_valid", a_rsp_valid, 0);
    check("rsp_taken_ready", a_req_ready, 1);
  endtask

  task automatic b_req(input logic we, input logic [2:0] addr, input logic [7:0] wd,
                       output int lat, output int sel_cnt, output int multi,
                       output logic err, output logic [7:0] rd);
    int g;
    @(posedge clk); #2;
    b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wd;
    b_rsp_ready = 1'b1;
    g = 0;
    do begin @(negedge clk); g++; end while (!b_req_ready && g < 50);
    check("b_handshake_wait", (g < 50), 1);
    @(posedge clk); #2;
    b_req_valid = 1'b0;
    lat = 0; sel_cnt = 0; multi = 0;
    do begin
      @(negedge clk);
      lat++;
      if (b_mem_sel != 6'b0) sel_cnt++;
      if ($countones(b_mem_sel) > 1) multi++;
    end while (!b_rsp_valid && lat < 30);
    err = b_rsp_err;
    rd  = b_rsp_rdata;
    @(posedge clk); #2;
  endtask

  logic [7:0] rd;
  logic       err;
  int         lat, sel_cnt, multi, cnt;

  initial begin
    rst_n = 1'b0;
    a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b1;
    b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0; b_rsp_ready = 1'b1;
    b_mem_rdata = 8'hFF;

    #3;
    check("init_req_ready_in_reset", a_req_ready, 0);
    check("init_b_req_ready_in_reset", b_req_ready, 0);
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("req_ready_after_release", a_req_ready, 1);
    check("b_req_ready_after_release", b_req_ready, 1);

    // Write 3 <= A5, then reads and a second row.
    a_req(1'b1, 3'd3, 8'hA5, 0, rd, err, lat);
    check("wr3_latency", lat, 4);
    check("wr3_rdata", rd, 8'h00);
    check("wr3_err", err, 0);
    check("wr3_setup_sel", sel_log[1], 8'h00);
    check("wr3_setup_rw", rw_log[1], 1);
    check("wr3_setup_wdata", wd_log[1], 8'hA5);
    check("wr3_strobe_sel", sel_log[2], 8'h08);
    check("wr3_hold_sel", sel_log[3], 8'h00);
    check("wr3_hold_rw", rw_log[3], 1);

    a_req(1'b0, 3'd3, 8'h00, 0, rd, err, lat);
    check("rd3_latency", lat, 4);
    check("rd3_rdata", rd, 8'hA5);
    check("rd3_rw_low", {rw_log[1], rw_log[2], rw_log[3]}, 3'b000);
    check("rd3_strobe_sel", sel_log[2], 8'h08);

    a_req(1'b1, 3'd7, 8'h3C, 0, rd, err, lat);
    check("wr7_strobe_sel", sel_log[2], 8'h80);
    a_req(1'b0, 3'd7, 8'h00, 0, rd, err, lat);
    check("rd7_rdata", rd, 8'h3C);
    a_req(1'b0, 3'd3, 8'h00, 0, rd, err, lat);
    check("rd3_again_rdata", rd, 8'hA5);

    // Response back-pressure for five cycles.
    a_req(1'b0, 3'd7, 8'h00, 5, rd, err, lat);
    check("hold_rd7_rdata", rd, 8'h3C);

    // Six-row instance: out-of-range read, three-cycle strobe write, in-range read.
    b_req(1'b0, 3'd6, 8'h00, lat, sel_cnt, multi, err, rd);
    check("b_oor_latency", lat, 2);
    check("b_oor_sel_cycles", sel_cnt, 0);
    check("b_oor_err", err, 1);
    check("b_oor_rdata", rd, 8'h00);
    b_req(1'b1, 3'd2, 8'h5A, lat, sel_cnt, multi, err, rd);
    check("b_wr_latency", lat, 6);
    check("b_wr_sel_cycles", sel_cnt, 3);
    check("b_wr_onehot", multi, 0);
    check("b_wr_err", err, 0);
    check("b_wr_rdata", rd, 8'h00);
    b_req(1'b0, 3'd5, 8'h00, lat, sel_cnt, multi, err, rd);
    check("b_rd_latency", lat, 6);
    check("b_rd_err", err, 0);
    check("b_rd_rdata", rd, 8'hFF);

    // Reset during the strobe of a write.
    @(posedge clk); #2;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 3'd5; a_req_wdata = 8'h77; a_rsp_ready = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", a_req_ready, 1);
    @(posedge clk); #2;
    a_req_valid = 1'b0;
    @(negedge clk);
    check("mid_rst_setup_rw", a_mem_rw, 1);
    @(negedge clk);
    check("mid_rst_strobe_sel", a_mem_sel, 8'h20);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_sel_drop", a_mem_sel, 8'h00);
    check("mid_rst_rw_drop", a_mem_rw, 0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (a_rsp_valid) cnt++;
    end
    check("mid_rst_no_rsp", cnt, 0);
    a_req(1'b0, 3'd3, 8'h00, 0, rd, err, lat);
    check("post_rst_rd3", rd, 8'hA5);
    check("post_rst_latency", lat, 4);
    a_req(1'b1, 3'd5, 8'h77, 0, rd, err, lat);
    a_req(1'b0, 3'd5, 8'h00, 0, rd, err, lat);
    check("post_rst_rd5", rd, 8'h77);

    // Random traffic: requests may come and go freely, back-pressure is random.
    for (int c = 0; c < 4000; c++) begin
      @(posedge clk); #2;
      a_req_valid = ($urandom_range(0, 2) != 0);
      a_req_we    = 1'($urandom_range(0, 1));
      a_req_addr  = 3'($urandom_range(0, 7));
      a_req_wdata = 8'($urandom_range(0, 255));
      a_rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #2;
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    repeat (10) @(negedge clk);
    check("final_idle_ready", a_req_ready, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
